// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front-end: frame geometry, the complex
// sample type, and the helpers that flatten a bank into the packed
// real/imag output buses (slot k at bits [k*DATA_W +: DATA_W]).
package fft_pkg;

   localparam int DATA_W = 16;
   localparam int FFT_N  = 8;
   localparam int IDX_W  = 3;

   typedef struct packed {
      logic [DATA_W-1:0] re;
      logic [DATA_W-1:0] im;
   } cplx_t;

   typedef cplx_t [FFT_N-1:0] frame_t;

   function automatic logic [FFT_N*DATA_W-1:0] pack_real(input frame_t f);
      logic [FFT_N*DATA_W-1:0] v;
      v = '0;
      for (int k = 0; k < FFT_N; k++) begin
         v[k*DATA_W +: DATA_W] = f[k].re;
      end
      return v;
   endfunction

   function automatic logic [FFT_N*DATA_W-1:0] pack_imag(input frame_t f);
      logic [FFT_N*DATA_W-1:0] v;
      v = '0;
      for (int k = 0; k < FFT_N; k++) begin
         v[k*DATA_W +: DATA_W] = f[k].im;
      end
      return v;
   endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One FFT_N-entry complex sample bank.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears all slots)
//   i_we      - write enable
//   i_widx    - slot written when i_we is high
//   i_wdata   - complex sample to store
//   o_frame   - all slots, presented in parallel
module fft_frame_bank
   import fft_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_widx,
   input  cplx_t            i_wdata,
   output frame_t           o_frame
);

   cplx_t r_slot [FFT_N];

   generate
      for (genvar gi = 0; gi < FFT_N; gi++) begin : g_slot
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_slot[gi] <= '0;
            end else if (i_we && (i_widx == IDX_W'(gi))) begin
               r_slot[gi] <= i_wdata;
            end
         end
      end
   endgenerate

   always_comb begin
      o_frame = '0;
      for (int k = 0; k < FFT_N; k++) begin
         o_frame[k] = r_slot[k];
      end
   end

endmodule

// File: rtl/fft_frame_loader.sv
// Serial-to-frame loader for the 8-point FFT. Samples arriving over a
// valid/ready stream are collected into one of two ping-pong banks; a
// completed bank is offered to the FFT as a whole frame under its own
// valid/ready handshake while the other bank keeps filling.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   s_valid/s_ready     - sample handshake
//   s_real/s_imag       - sample components (two's complement)
//   s_last              - end-of-frame marker, expected on index FFT_N-1
//   f_valid/f_ready     - frame handshake
//   f_real/f_imag       - packed frame, slot k at [k*DATA_W +: DATA_W]
//   frame_err           - one-cycle pulse on a framing error
module fft_frame_loader
   import fft_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [DATA_W-1:0]       s_real,
   input  logic [DATA_W-1:0]       s_imag,
   input  logic                    s_last,
   output logic                    f_valid,
   input  logic                    f_ready,
   output logic [FFT_N*DATA_W-1:0] f_real,
   output logic [FFT_N*DATA_W-1:0] f_imag,
   output logic                    frame_err
);

   logic             r_wr_bank;
   logic             r_rd_bank;
   logic [IDX_W-1:0] r_wr_idx;
   logic [1:0]       r_full;
   logic             r_frame_err;

   logic             w_accept;
   logic             w_idx_last;
   logic             w_consume;
   logic [1:0]       w_full_next;
   logic [1:0]       w_bank_we;
   cplx_t            w_wdata;
   frame_t           w_bank_frame [2];
   frame_t           w_rd_frame;

   // Readiness depends only on registered flags, so f_ready never reaches
   // s_ready in the same cycle.
   assign s_ready    = !r_full[r_wr_bank];
   assign f_valid    = r_full[r_rd_bank];
   assign frame_err  = r_frame_err;

   assign w_accept   = s_valid && s_ready;
   assign w_idx_last = (r_wr_idx == IDX_W'(FFT_N-1));
   assign w_consume  = f_valid && f_ready;
   assign w_wdata    = '{re: s_real, im: s_imag};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_bank
         assign w_bank_we[gi] = w_accept && (r_wr_bank == 1'(gi));

         fft_frame_bank u_bank (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_bank_we[gi]),
            .i_widx  (r_wr_idx),
            .i_wdata (w_wdata),
            .o_frame (w_bank_frame[gi])
         );
      end
   endgenerate

   assign w_rd_frame = w_bank_frame[r_rd_bank];
   assign f_real     = pack_real(w_rd_frame);
   assign f_imag     = pack_imag(w_rd_frame);

   // The consumed bank is full and the completing bank is not, so the two
   // updates never target the same flag.
   always_comb begin
      w_full_next = r_full;
      if (w_consume) begin
         w_full_next[r_rd_bank] = 1'b0;
      end
      if (w_accept && w_idx_last) begin
         w_full_next[r_wr_bank] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_bank   <= 1'b0;
         r_rd_bank   <= 1'b0;
         r_wr_idx    <= '0;
         r_full      <= 2'b00;
         r_frame_err <= 1'b0;
      end else begin
         r_full      <= w_full_next;
         r_frame_err <= 1'b0;
         if (w_consume) begin
            r_rd_bank <= ~r_rd_bank;
         end
         if (w_accept) begin
            if (w_idx_last) begin
               // Frame completes even without s_last; that case is flagged.
               r_wr_bank   <= ~r_wr_bank;
               r_wr_idx    <= '0;
               r_frame_err <= !s_last;
            end else if (s_last) begin
               // Early end: drop the partial frame and refill the same bank.
               r_wr_idx    <= '0;
               r_frame_err <= 1'b1;
            end else begin
               r_wr_idx <= r_wr_idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_loader.sv
module tb_fft_frame_loader;

   logic         clk;
   logic         rst;
   logic         s_valid;
   logic         s_ready;
   logic [15:0]  s_real;
   logic [15:0]  s_imag;
   logic         s_last;
   logic         f_valid;
   logic         f_ready;
   logic [127:0] f_real;
   logic [127:0] f_imag;
   logic         frame_err;

   typedef struct packed {
      logic [127:0] re;
      logic [127:0] im;
   } frm_t;

   frm_t exp_q[$];
   int   n_checks;
   int   n_fail;
   int   stall_cycles;

   fft_frame_loader dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_real    (s_real),
      .s_imag    (s_imag),
      .s_last    (s_last),
      .f_valid   (f_valid),
      .f_ready   (f_ready),
      .f_real    (f_real),
      .f_imag    (f_imag),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Scoreboard monitor: every frame handshake is compared with the oldest expected frame.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && f_valid && f_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL frame_unexpected: got re=%h, no frame expected", f_real);
            end else begin
               frm_t e;
               e = exp_q.pop_front();
               n_checks--;
               check("frame_real", f_real, e.re);
               check("frame_imag", f_imag, e.im);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && s_valid && !s_ready) stall_cycles++;
   end

   // Sends one sample; waits (bounded) for s_ready.
   task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
      int waited;
      s_valid = 1'b1;
      s_real  = re;
      s_imag  = im;
      s_last  = last;
      waited  = 0;
      @(negedge clk);
      while (!s_ready && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      if (!s_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: s_ready=%0b required 1", s_ready);
         s_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         s_valid = 1'b0;
         s_last  = 1'b0;
      end
   endtask

   // Sends n samples real=base+k, imag=-(base+k); s_last at index last_at.
   task automatic send_frame(input int base, input int n, input int last_at, input bit push);
      frm_t e;
      e = '0;
      for (int k = 0; k < 8; k++) begin
         e.re[k*16 +: 16] = 16'(base + k);
         e.im[k*16 +: 16] = 16'(-(base + k));
      end
      if (push) exp_q.push_back(e);
      for (int k = 0; k < n; k++) begin
         send(16'(base + k), 16'(-(base + k)), k == last_at);
      end
   endtask

   // Holds f_ready until the scoreboard is empty, then checks nothing remains.
   task automatic drain();
      f_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) break;
      end
      f_ready = 1'b0;
      check("drain_done", 128'(exp_q.size()), 128'd0);
      check("drain_f_valid", 128'(f_valid), 128'd0);
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      stall_cycles = 0;
      rst = 1'b1;
      s_valid = 1'b0;
      s_real = '0;
      s_imag = '0;
      s_last = 1'b0;
      f_ready = 1'b0;

      // Reset state
      #12;
      check("rst_s_ready", 128'(s_ready), 128'd1);
      check("rst_f_valid", 128'(f_valid), 128'd0);
      check("rst_f_real", f_real, 128'd0);
      check("rst_f_imag", f_imag, 128'd0);
      check("rst_frame_err", 128'(frame_err), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single frame, hand-computed packing
      send_frame(1, 7, 7, 1'b1);
      check("single_f_valid_before", 128'(f_valid), 128'd0);
      send(16'd8, 16'hFFF8, 1'b1);
      check("single_f_valid", 128'(f_valid), 128'd1);
      check("single_s_ready", 128'(s_ready), 128'd1);
      check("single_real", f_real, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
      check("single_imag", f_imag, 128'hFFF8_FFF9_FFFA_FFFB_FFFC_FFFD_FFFE_FFFF);
      check("single_err", 128'(frame_err), 128'd0);
      drain();

      // Backpressure: two frames fill both banks, third stalls
      send_frame(100, 8, 7, 1'b1);
      send_frame(200, 8, 7, 1'b1);
      check("bp_s_ready_low", 128'(s_ready), 128'd0);
      check("bp_f_valid", 128'(f_valid), 128'd1);
      check("bp_frame1_real", f_real,
            128'h006B_006A_0069_0068_0067_0066_0065_0064);
      fork
         send_frame(300, 8, 7, 1'b1);
         begin
            repeat (4) @(negedge clk);
            check("bp_stall", 128'(s_ready), 128'd0);
            @(posedge clk);
            #1;
            f_ready = 1'b1;
            @(negedge clk);
            check("bp_no_comb_ready", 128'(s_ready), 128'd0);
            @(posedge clk);
            #1;
            f_ready = 1'b0;
            @(negedge clk);
            check("bp_s_ready_return", 128'(s_ready), 128'd1);
            check("bp_frame2_real", f_real,
                  128'h00CF_00CE_00CD_00CC_00CB_00CA_00C9_00C8);
         end
      join
      drain();

      // Continuous streaming: 64 samples, f_ready held high
      stall_cycles = 0;
      f_ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
         send_frame(8*n, 8, 7, 1'b1);
      end
      check("stream_no_stall", 128'(stall_cycles), 128'd0);
      drain();

      // Early s_last on index 4
      send_frame(500, 5, 4, 1'b0);
      check("early_err_pulse", 128'(frame_err), 128'd1);
      check("early_f_valid", 128'(f_valid), 128'd0);
      @(posedge clk);
      #1;
      check("early_err_one_cycle", 128'(frame_err), 128'd0);
      check("early_f_valid_later", 128'(f_valid), 128'd0);
      send_frame(600, 8, 7, 1'b1);
      check("early_clean_err", 128'(frame_err), 128'd0);
      drain();

      // Missing s_last
      send_frame(700, 8, 99, 1'b1);
      check("miss_err_pulse", 128'(frame_err), 128'd1);
      check("miss_f_valid", 128'(f_valid), 128'd1);
      @(posedge clk);
      #1;
      check("miss_err_one_cycle", 128'(frame_err), 128'd0);
      drain();

      // Reset mid-frame with one full bank pending
      send_frame(800, 8, 7, 1'b0);
      send_frame(900, 5, 7, 1'b0);
      check("pre_rst_f_valid", 128'(f_valid), 128'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mrst_f_valid", 128'(f_valid), 128'd0);
      check("mrst_s_ready", 128'(s_ready), 128'd1);
      check("mrst_f_real", f_real, 128'd0);
      check("mrst_frame_err", 128'(frame_err), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      send_frame(1000, 8, 7, 1'b1);
      check("post_rst_err", 128'(frame_err), 128'd0);
      check("post_rst_real", f_real,
            128'h03EF_03EE_03ED_03EC_03EB_03EA_03E9_03E8);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Front-end feeding the 8-point radix-2 FFT datapath.
- Accepts a serial stream of complex 16-bit samples over a valid/ready handshake and assembles them into frames of 8 in natural order (slot k = in_k).
- Presents each complete frame as 8 parallel real/imag words under a frame-level valid/ready handshake.
- Ping-pong double buffering allows back-to-back frames without stalling the stream.

Parameters:
- DATA_W, 16, width of each real/imag component.
- FFT_N, 8, samples per frame; power of two.
- IDX_W, 3, log2(FFT_N); sample index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  input sample valid.
- s_ready  output  1  loader can accept a sample.
- s_real  input  DATA_W  sample real part, two's complement.
- s_imag  input  DATA_W  sample imaginary part, two's complement.
- s_last  input  1  marks the last sample of a frame; expected only on index FFT_N-1.
- f_valid  output  1  a complete frame is presented.
- f_ready  input  1  FFT datapath consumes the frame.
- f_real  output  FFT_N*DATA_W  frame real parts; slot k at bits [k*DATA_W +: DATA_W].
- f_imag  output  FFT_N*DATA_W  frame imaginary parts, same packing as f_real.
- frame_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- State:
  - two banks, B0 and B1, each FFT_N x (real, imag) registers;
  - wr_bank (1b), wr_idx (IDX_W), rd_bank (1b);
  - full[1:0] flags.
- Reset (asynchronous, rst=1): all bank registers 0, full=00, wr_bank=0, rd_bank=0, wr_idx=0, frame_err=0. Outputs during and after reset: s_ready=1, f_valid=0, f_real=0, f_imag=0.
- Combinational outputs:
  - s_ready = !full[wr_bank];
  - f_valid = full[rd_bank];
  - f_real/f_imag = contents of bank rd_bank.
- Sample accept: an accept occurs when s_valid && s_ready at a clock edge. On accept, bank[wr_bank][wr_idx] <= {s_real, s_imag}.
- Frame completion:
  - Condition: accept with wr_idx == FFT_N-1.
  - Action: full[wr_bank] <= 1, wr_bank toggles, wr_idx <= 0. Otherwise wr_idx increments by 1 per accept.
  - Latency: last sample accepted at edge t gives f_valid=1 from t+1 (one register stage). No combinational path from s_* to f_*.
- Frame consume: when f_valid && f_ready, full[rd_bank] <= 0 and rd_bank toggles.
- Framing errors (frame_err registered, high for exactly one cycle after the offending edge):
  - s_last=1 on accept with wr_idx < FFT_N-1: the sample is written, the partial frame is discarded, wr_idx <= 0, wr_bank unchanged, full unchanged, frame_err=1.
  - s_last=0 on accept with wr_idx == FFT_N-1: the frame completes normally and frame_err=1.
- Simultaneous events:
  - Completion of bank X and consume of bank Y in the same cycle are both applied.
  - Consume of the bank equal to wr_bank frees it; s_ready rises the next cycle, never the same cycle (no f_ready-to-s_ready combinational path).
  - Both banks full: s_ready=0 and the input stalls; there is no data loss.
- Ordering: frames are presented in arrival order. Banks strictly alternate, and a bank is never overwritten while full.
- Throughput: with f_ready held at 1, one sample per cycle is sustained indefinitely; s_ready never drops.
- Reset mid-frame: the partial frame and any full banks are discarded; no frame_err is generated.
- Arithmetic: none. Data is stored and forwarded bit-exact, with no scaling.

Decomposition:
- Shared package fft_pkg holds:
  - DATA_W=16, FFT_N=8, IDX_W=3;
  - a complex sample struct {real, imag};
  - the slot-packing helper.
- Sub-module fft_frame_bank:
  - one FFT_N-entry complex register bank with write-enable and write-index ports;
  - asynchronously reset to 0;
  - instantiated twice.
- Control (indices, full flags, error) stays in fft_frame_loader.

Test Plan:
- Single frame:
  - Stimulus: after reset, stream real=k+1, imag=-(k+1) for k=0..7, s_last on k=7, f_ready=0.
  - Response: f_valid=1 one cycle after the 8th accept; f_real slots = 1..8; f_imag slots = 0xFFFF..0xFFF8; s_ready stays 1.
- Backpressure:
  - Stimulus: stream 3 full frames with f_ready=0.
  - Response: s_ready=0 after the 16th accept, the 17th sample stalls, nothing is overwritten. Raising f_ready for one cycle presents frame 1, then frame 2; s_ready returns 1 one cycle after the consume.
- Continuous streaming:
  - Stimulus: f_ready=1, 64 consecutive samples valued 0..63.
  - Response: 8 frames with no s_ready drop; frame n slot k = 8n+k.
- Early s_last:
  - Stimulus: s_last on index 4.
  - Response: frame_err pulses once, no f_valid. The next 8 samples (s_last on 7) form a clean frame with slot 0 = first sample after the error.
- Missing s_last:
  - Stimulus: 8 samples with s_last=0.
  - Response: frame presented and frame_err pulses once.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously after 5 samples with one full bank pending.
  - Response: immediately f_valid=0, s_ready=1, f_real=0, frame_err=0. The next 8 samples form frame slot 0..7 correctly.
